// File: rtl/inst_enco_pkg.sv
// inst_enco_pkg: shared instruction-word layout, format codes and FSM encoding
package inst_enco_pkg;
    localparam int INST_W  = 19;
    localparam int OP_W    = 5;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 10;
    localparam int OP_LSB  = 14;
    localparam int RS1_LSB = 10;
    localparam int RS2_LSB = 6;
    localparam int RD_LSB  = 2;
    localparam int IMM_LSB = 0;
    localparam logic FMT_R = 1'b0;
    localparam logic FMT_I = 1'b1;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/inst_enco_pack.sv
// inst_pack: packs instruction fields into a 19-bit word per format
module inst_pack
    import inst_enco_pkg::*;
(
    input  logic              fmt_i,
    input  logic [OP_W-1:0]   opcode_i,
    input  logic [REG_W-1:0]  rs1_i,
    input  logic [REG_W-1:0]  rs2_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [INST_W-1:0] word_o
);
    // immediate overlays the rs2/rd/pad bits; register format leaves the low two bits zero
    always_comb begin
        word_o = '0;
        word_o[OP_LSB +: OP_W]   = opcode_i;
        word_o[RS1_LSB +: REG_W] = rs1_i;
        if (fmt_i == FMT_I) begin
            word_o[IMM_LSB +: IMM_W] = imm_i;
        end else begin
            word_o[RS2_LSB +: REG_W] = rs2_i;
            word_o[RD_LSB +: REG_W]  = rd_i;
        end
    end
endmodule

// File: rtl/inst_enco.sv
// inst_enco: session-based instruction encoder writing packed words to program memory
module inst_enco
    import inst_enco_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fmt,
    input  logic [OP_W-1:0]   opcode,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [REG_W-1:0]  rd,
    input  logic [IMM_W-1:0]  immediate,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t              state_q, state_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W-1:0]   nxt_q, nxt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [INST_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [INST_W-1:0]   packed_word;
    logic                accept, wr_done, too_big;

    inst_pack u_pack (
        .fmt_i    (fmt),
        .opcode_i (opcode),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .rd_i     (rd),
        .imm_i    (immediate),
        .word_o   (packed_word)
    );

    assign in_ready  = (state_q == S_LOAD) && (!we_q || mem_ready);
    assign accept    = in_valid && in_ready;
    assign wr_done   = we_q && mem_ready;
    assign too_big   = count[ADDR_W] && (count[ADDR_W-1:0] != '0);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q || ((state_q == S_DRAIN) && wr_done);
    assign err       = err_q;

    // next state: an accept reloads the output register so back-to-back writes need no bubble
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        nxt_d   = nxt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q && !mem_ready;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            addr_d  = nxt_q;
            nxt_d   = nxt_q + 1'b1;
            wdata_d = packed_word;
            we_d    = 1'b1;
            rem_d   = rem_q - 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else if (too_big) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        rem_d   = count;
                        nxt_d   = base_addr;
                    end
                end
            end
            S_LOAD:  state_d = (accept && rem_q == (ADDR_W+1)'(1)) ? S_DRAIN : S_LOAD;
            S_DRAIN: state_d = wr_done ? S_IDLE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers; reset drops any pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            nxt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            nxt_q   <= nxt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_inst_enco.sv
// tb_inst_enco: directed and randomized sessions checked against a queue-based write model
module tb_inst_enco;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        fmt = 1'b0;
    logic [4:0]  opcode = '0;
    logic [3:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [9:0]  immediate = '0;
    logic        mem_we;
    logic        mem_ready = 1'b0;
    logic [7:0]  mem_addr;
    logic [18:0] mem_wdata;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, we_cnt = 0, cyc = 0;
    logic [26:0] exp_q[$];
    logic [26:0] got_q[$];
    int          got_t[$];
    logic        stall_prev = 1'b0, rst_prev = 1'b1;
    logic [7:0]  p_addr = '0;
    logic [18:0] p_data = '0;

    inst_enco #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] enc(input logic f, input int op, input int r1, input int r2,
                                        input int rdv, input int im);
        int v;
        v = op * 16384 + r1 * 1024 + (f ? im : r2 * 64 + rdv * 4);
        return v[18:0];
    endfunction

    // write monitor: logs completed writes and checks hold/stall behaviour
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && !rst_prev) begin
                chk("hold_we", mem_we, 1);
                chk("hold_addr", mem_addr, p_addr);
                chk("hold_data", mem_wdata, p_data);
            end
            if (mem_we && !mem_ready) chk("stall_in_ready", in_ready, 0);
            if (mem_we && mem_ready) begin
                got_q.push_back({mem_addr, mem_wdata});
                got_t.push_back(cyc);
            end
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
            if (mem_we === 1'b1) we_cnt++;
        end
        stall_prev = mem_we && !mem_ready;
        p_addr = mem_addr;
        p_data = mem_wdata;
        rst_prev = rst;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic session(input int c, input int b, input int rdy_pct, input int vld_pct, input bit rnd);
        int k;
        bit to;
        k = 0;
        to = 1'b1;
        exp_q.delete();
        got_q.delete();
        got_t.delete();
        done_cnt = 0;
        err_cnt = 0;
        start = 1'b1;
        base_addr = 8'(b);
        count = 9'(c);
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            mem_ready = ($urandom_range(99) < rdy_pct);
            in_valid = ($urandom_range(99) < vld_pct);
            if (rnd) begin
                fmt = 1'($urandom);
                opcode = 5'($urandom);
                rs1 = 4'($urandom);
                rs2 = 4'($urandom);
                rd = 4'($urandom);
                immediate = 10'($urandom);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back({8'(b + k), enc(fmt, int'(opcode), int'(rs1), int'(rs2), int'(rd), int'(immediate))});
                k++;
            end
            tick();
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        in_valid = 1'b0;
        mem_ready = 1'b0;
        repeat (2) tick();
        chk("timeout", 32'(to), 0);
        chk("accepted", k, c);
        chk("nwrites", got_q.size(), c);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("write", got_q[i], exp_q[i]);
        chk("done_count", done_cnt, 1);
        chk("err_count", err_cnt, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_wdata, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // single register-format instruction
        tick();
        start = 1'b1; base_addr = 8'h10; count = 9'd1; mem_ready = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; fmt = 1'b0; opcode = 5'h03; rs1 = 4'h1; rs2 = 4'h2; rd = 4'h3;
        @(negedge clk);
        chk("r_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("r_we", mem_we, 1);
        chk("r_addr", mem_addr, 32'h10);
        chk("r_data", mem_wdata, 32'h0C48C);
        chk("r_done", done, 1);
        tick();
        @(negedge clk);
        chk("r_busy_after", busy, 0);
        chk("r_done_after", done, 0);
        chk("r_we_after", mem_we, 0);
        tick();

        // immediate format with address wrap
        fmt = 1'b1; opcode = 5'h1F; rs1 = 4'hA; immediate = 10'h3FF; rs2 = 4'h5; rd = 4'h6;
        session(2, 'hFF, 100, 100, 0);
        if (got_q.size() == 2) begin
            chk("i_addr0", got_q[0][26:19], 32'hFF);
            chk("i_data0", got_q[0][18:0], 32'h7EBFF);
            chk("i_addr1", got_q[1][26:19], 32'h00);
        end

        // back-to-back throughput
        session(4, $urandom_range(255), 100, 100, 1);
        if (got_t.size() == 4) chk("b2b_span", got_t[3] - got_t[0], 3);

        // zero-length and oversized sessions
        done_cnt = 0; err_cnt = 0; we_cnt = 0;
        start = 1'b1; count = 9'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_err", err, 0);
        chk("zero_busy", busy, 0);
        tick();
        start = 1'b1; count = 9'd257;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("big_err", err, 1);
        chk("big_done", done, 0);
        chk("big_busy", busy, 0);
        repeat (4) tick();
        chk("big_no_we", we_cnt, 0);
        chk("big_err_once", err_cnt, 1);
        chk("zero_done_once", done_cnt, 1);

        // stalled write, then reset mid-session
        done_cnt = 0;
        start = 1'b1; base_addr = 8'h20; count = 9'd3; mem_ready = 1'b0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; fmt = 1'b0; opcode = 5'h07; rs1 = 4'h2; rs2 = 4'h4; rd = 4'h8;
        @(negedge clk);
        chk("stall_first_ready", in_ready, 1);
        tick();
        opcode = 5'h09;
        repeat (3) begin
            @(negedge clk);
            chk("stall_we", mem_we, 1);
            chk("stall_addr", mem_addr, 32'h20);
            chk("stall_data", mem_wdata, 32'(enc(0, 7, 2, 4, 8, 0)));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        repeat (3) tick();
        chk("rst_mid_no_done", done_cnt, 0);
        session(3, 'h30, 40, 70, 1);

        // full-size session and randomized sessions
        session(256, $urandom_range(255), 100, 100, 1);
        for (int s = 0; s < 15; s++)
            session($urandom_range(10, 1), $urandom_range(255), $urandom_range(100, 30),
                    $urandom_range(100, 30), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
